// File: rtl/irq_sched_pkg.sv
// Shared sizes, FSM state type and register map for the interrupt scheduler.
// Pure declarations: no logic, no latency, no flow control.
package irq_sched_pkg;

    localparam int NSRC = 5;
    localparam int NLVL = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [3:0] PRIO   = 4'd0;
    localparam logic [3:0] STAT   = 4'd1;
    localparam logic [3:0] EOI    = 4'd2;
    localparam logic [3:0] ERR    = 4'd3;
    localparam logic [3:0] ACKCNT = 4'd4;

endpackage

// File: rtl/irq_sched_pick.sv
// Combinational winner select: highest eligible priority, ties to lowest index.
// Zero latency; there is no flow control, and the result is valid every cycle.
module irq_pick #(
    parameter int NSRC = 5,
    parameter int NLVL = 4
) (
    input  logic [NSRC-1:0]   pending,
    input  logic [2*NSRC-1:0] prio,
    input  logic [NLVL-1:0]   insvc,
    output logic              any,
    output logic [2:0]        win_idx,
    output logic [1:0]        win_lvl
);

    logic       run_vld;
    logic [1:0] run_lvl;
    logic [1:0] p;

    always_comb begin
        run_vld = 1'b0;
        run_lvl = 2'd0;
        for (int l = 0; l < NLVL; l++) begin
            if (insvc[l]) begin
                run_vld = 1'b1;
                run_lvl = 2'(l);
            end
        end

        any     = 1'b0;
        win_idx = 3'd0;
        win_lvl = 2'd0;
        p       = 2'd0;
        // Strict compare keeps the earlier (lower-index) source on a tie.
        for (int i = 0; i < NSRC; i++) begin
            p = prio[2*i +: 2];
            if (pending[i] && (!run_vld || p > run_lvl) && (!any || p > win_lvl)) begin
                any     = 1'b1;
                win_idx = 3'(i);
                win_lvl = p;
            end
        end
    end

endmodule

// File: rtl/irq_sched.sv
// Priority interrupt scheduler with nested in-service tracking and a register bus.
// cpu_irq rises one cycle after a source becomes eligible and is held until ack or withdrawal.
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int NSRC = irq_sched_pkg::NSRC,
    parameter int NLVL = irq_sched_pkg::NLVL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  pending,
    output logic             cpu_irq,
    output logic [2:0]       cpu_vector,
    input  logic             cpu_ack,
    input  logic             io_write,
    input  logic [3:0]       io_addr,
    input  logic [15:0]      io_wdata,
    output logic [15:0]      io_rdata
);

    state_t              state_q, state_d;
    logic [2*NSRC-1:0]   r_prio;
    logic [NLVL-1:0]     r_insvc, insvc_d;
    logic [2:0]          r_vec;
    logic [1:0]          r_lvl;
    logic [2:0]          r_err, err_set, err_clr;
    logic [15:0]         r_ackcnt;

    logic                any;
    logic [2:0]          win_idx;
    logic [1:0]          win_lvl;
    logic                take_ack, withdraw, eoi, found;

    irq_pick #(.NSRC(NSRC), .NLVL(NLVL)) u_pick (
        .pending (pending),
        .prio    (r_prio),
        .insvc   (r_insvc),
        .any     (any),
        .win_idx (win_idx),
        .win_lvl (win_lvl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        take_ack = 1'b0;
        withdraw = 1'b0;
        case (state_q)
            IDLE:  if (any) state_d = OFFER;
            OFFER: begin
                if (cpu_ack) begin
                    take_ack = 1'b1;
                    state_d  = IDLE;
                end else if (!pending[r_vec]) begin
                    withdraw = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // EOI works on the pre-cycle mask; a same-cycle ack is ORed in afterwards.
    always_comb begin
        eoi     = io_write && (io_addr == EOI);
        insvc_d = r_insvc;
        found   = 1'b0;
        if (eoi) begin
            for (int l = NLVL-1; l >= 0; l--) begin
                if (!found && r_insvc[l]) begin
                    insvc_d[l] = 1'b0;
                    found      = 1'b1;
                end
            end
        end
        if (take_ack) insvc_d[r_lvl] = 1'b1;

        err_set = {(state_q == IDLE) && cpu_ack, withdraw, eoi && (r_insvc == '0)};
        err_clr = (io_write && io_addr == ERR) ? io_wdata[2:0] : 3'b000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio   <= '0;
            r_insvc  <= '0;
            r_vec    <= 3'd0;
            r_lvl    <= 2'd0;
            r_err    <= 3'b000;
            r_ackcnt <= 16'd0;
        end else begin
            if (io_write && io_addr == PRIO) r_prio <= io_wdata[2*NSRC-1:0];
            if (state_q == IDLE && any) begin
                r_vec <= win_idx;
                r_lvl <= win_lvl;
            end
            r_insvc <= insvc_d;
            r_err   <= (r_err & ~err_clr) | err_set;
            if (take_ack) r_ackcnt <= r_ackcnt + 16'd1;
        end
    end

    assign cpu_irq    = (state_q == OFFER);
    assign cpu_vector = r_vec;

    always_comb begin
        io_rdata = 16'd0;
        case (io_addr)
            PRIO:    io_rdata[2*NSRC-1:0] = r_prio;
            STAT:    io_rdata = {state_q == OFFER, 4'b0, r_vec, 4'b0, 4'(r_insvc)};
            ERR:     io_rdata = {13'b0, r_err};
            ACKCNT:  io_rdata = r_ackcnt;
            default: io_rdata = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_sched.sv
// Scoreboard bench for irq_sched: expected vectors queued at stimulus, popped on offer.
module tb_irq_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pending;
    logic        cpu_irq;
    logic [2:0]  cpu_vector;
    logic        cpu_ack;
    logic        io_write;
    logic [3:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    int total = 0;
    int bad   = 0;
    int exp_ack = 0;
    int exp_q[$];
    logic [15:0] rv;

    irq_sched dut (
        .clk        (clk),
        .reset      (reset),
        .pending    (pending),
        .cpu_irq    (cpu_irq),
        .cpu_vector (cpu_vector),
        .cpu_ack    (cpu_ack),
        .io_write   (io_write),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        io_addr = a;
        #1;
        d = io_rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        io_write = 1'b1;
        io_addr  = a;
        io_wdata = d;
        tick();
        io_write = 1'b0;
        io_wdata = 16'd0;
    endtask

    task automatic ack();
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        exp_ack++;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        int e;
        while (!cpu_irq && n < 20) begin
            tick();
            n++;
        end
        if (!cpu_irq) begin
            check({tag, "_timeout"}, 0, 1);
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, int'(cpu_vector), -1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_vec"}, int'(cpu_vector), e);
        end
    endtask

    task automatic chk_insvc(input string tag, input int exp);
        rd(4'd1, rv);
        check(tag, int'(rv[3:0]), exp);
    endtask

    task automatic chk_err(input string tag, input int exp);
        rd(4'd3, rv);
        check(tag, int'(rv), exp);
    endtask

    initial begin
        reset = 1'b1; pending = 5'd0; cpu_ack = 1'b0;
        io_write = 1'b0; io_addr = 4'd0; io_wdata = 16'd0;
        tick(2);
        check("rst_irq", int'(cpu_irq), 0);
        check("rst_vec", int'(cpu_vector), 0);
        rd(4'd0, rv); check("rst_prio", int'(rv), 0);
        rd(4'd1, rv); check("rst_stat", int'(rv), 0);
        chk_err("rst_err", 0);
        rd(4'd4, rv); check("rst_ackcnt", int'(rv), 0);
        reset = 1'b0;
        tick();

        // all priorities 0, two sources: lowest index wins
        pending = 5'b00110; exp_q.push_back(1);
        tick();
        check("t1_latency", int'(cpu_irq), 1);
        wait_irq("t1");
        pending = 5'b00000;
        ack();
        rd(4'd1, rv); check("t1_stat", int'(rv), 16'h0101);
        rd(4'd4, rv); check("t1_ackcnt", int'(rv), exp_ack);
        wr(4'd2, 16'hffff);
        chk_insvc("t1_eoi", 0);

        // src4 at level 3 beats src0 at level 1; src0 waits for EOI
        wr(4'd0, 16'h0301);
        rd(4'd0, rv); check("t2_prio", int'(rv), 16'h0301);
        pending = 5'b10001; exp_q.push_back(4);
        wait_irq("t2a");
        pending = 5'b00001;
        ack();
        chk_insvc("t2_insvc", 4'b1000);
        tick(3);
        check("t2_blocked", int'(cpu_irq), 0);
        wr(4'd2, 16'd0);
        exp_q.push_back(0);
        wait_irq("t2b");
        pending = 5'b00000;
        ack();
        chk_insvc("t2_src0", 4'b0010);

        // nesting: src3 at level 2 preempts running level 1
        wr(4'd0, 16'h0381);
        pending = 5'b01000; exp_q.push_back(3);
        wait_irq("t3");
        pending = 5'b00000;
        ack();
        chk_insvc("t3_nest", 4'b0110);
        wr(4'd2, 16'd0); chk_insvc("t3_eoi1", 4'b0010);
        wr(4'd2, 16'd0); chk_insvc("t3_eoi2", 4'b0000);
        chk_err("t3_noerr", 0);
        wr(4'd2, 16'd0); chk_err("t3_eoi_err", 3'b001);
        wr(4'd3, 16'd1); chk_err("t3_clr", 0);

        // withdrawal
        pending = 5'b00100; exp_q.push_back(2);
        wait_irq("t4");
        pending = 5'b00000;
        tick();
        check("t4_drop", int'(cpu_irq), 0);
        chk_err("t4_spur", 3'b010);
        chk_insvc("t4_insvc", 0);
        wr(4'd3, 16'd2); chk_err("t4_clr", 0);

        // ack while idle; then set beats same-cycle clear
        ack(); exp_ack--;
        chk_err("t5_idle_ack", 3'b100);
        rd(4'd4, rv); check("t5_ackcnt", int'(rv), exp_ack);
        cpu_ack = 1'b1;
        wr(4'd3, 16'd4);
        cpu_ack = 1'b0;
        chk_err("t5_set_wins", 3'b100);
        wr(4'd3, 16'd4); chk_err("t5_clr", 0);

        // ack and EOI together with insvc=0010, r_lvl=3
        pending = 5'b00001; exp_q.push_back(0);
        wait_irq("t6a");
        pending = 5'b10000;
        ack();
        chk_insvc("t6_pre", 4'b0010);
        exp_q.push_back(4);
        wait_irq("t6b");
        pending = 5'b00000;
        cpu_ack = 1'b1; exp_ack++;
        wr(4'd2, 16'd0);
        cpu_ack = 1'b0;
        chk_insvc("t6_both", 4'b1000);
        chk_err("t6_err", 0);
        rd(4'd4, rv); check("t6_ackcnt", int'(rv), exp_ack);
        wr(4'd2, 16'd0);

        // reset in mid-offer
        pending = 5'b00100; exp_q.push_back(2);
        wait_irq("t7");
        #2 reset = 1'b1;
        #1;
        check("t7_irq_async", int'(cpu_irq), 0);
        check("t7_vec", int'(cpu_vector), 0);
        pending = 5'b00000;
        tick();
        rd(4'd0, rv); check("t7_prio", int'(rv), 0);
        rd(4'd1, rv); check("t7_stat", int'(rv), 0);
        chk_err("t7_err", 0);
        rd(4'd4, rv); check("t7_ackcnt", int'(rv), 0);
        reset = 1'b0;
        tick(2);
        check("t7_idle", int'(cpu_irq), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
